uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a per-bit cycle counter.
// Delivers good bytes with a one-cycle data_rdy pulse; flags bad stop bits with frame_err.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_rdy,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W    = 3;

  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [7:0]       shift_q,  shift_d;
  logic [7:0]       data_q,   data_d;
  logic             rdy_q,    rdy_d;
  logic             ferr_q,   ferr_d;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end

      // A start bit that is high again at its midpoint was a glitch.
      S_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leaves half a stop bit so an immediately following start edge is seen.
      S_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            rdy_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  assign data_out  = data_q;
  assign data_rdy  = rdy_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a sender task pushes expected bytes/frame errors to a
// scoreboard that a negedge monitor pops as data_rdy/frame_err pulses appear.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk_in;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_rdy;
  logic       frame_err;
  logic       busy;

  int checks;
  int failures;
  int cyc;
  int fe_pending;
  int fe_count;
  logic [7:0] exp_q[$];
  int         rdy_times[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_rdy  (data_rdy),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // p100 is the sender bit period in hundredths of a clock cycle.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int p100);
    logic [9:0] bits;
    int n;
    bits = {stop_bit, b, 1'b0};
    if (stop_bit) exp_q.push_back(b);
    else fe_pending++;
    for (int j = 0; j < 10; j++) begin
      rx_in = bits[j];
      n = (((j + 1) * p100 + 50) / 100) - ((j * p100 + 50) / 100);
      idle(n);
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (data_rdy || frame_err) chk("rdy_ferr_exclusive", 32'(data_rdy & frame_err), 32'd0);
      if (data_rdy) begin
        rdy_times.push_back(cyc);
        chk("busy_low_at_rdy", 32'(busy), 32'd0);
        chk("rdy_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (frame_err) begin
        fe_count++;
        chk("frame_err_expected", 32'(fe_pending > 0), 32'd1);
        if (fe_pending > 0) fe_pending--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int lat;
    int bc;
    int base;
    checks     = 0;
    failures   = 0;
    fe_pending = 0;
    fe_count   = 0;
    reset      = 1'b1;
    rx_in      = 1'b1;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_data_rdy", 32'(data_rdy), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    idle(5);

    // Single nominal frame and its latency.
    c0 = cyc;
    send(8'h65, 1'b1, 1600);
    idle(4);
    chk("rdy_count_0x65", 32'(rdy_times.size()), 32'd1);
    lat = (rdy_times.size() > 0) ? rdy_times[0] - c0 : -1;
    chk("rdy_latency_in_155_157", 32'(lat >= 155 && lat <= 157), 32'd1);
    chk("hold_0x65", 32'(data_out), 32'h65);
    chk("busy_after_0x65", 32'(busy), 32'd0);

    // Start-bit glitch of 4 cycles.
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (busy) bc++;
    end
    @(posedge clk_in);
    #1;
    chk("glitch_busy_len_ok", 32'(bc > 0 && bc <= HALF + 3), 32'd1);
    chk("glitch_busy_final", 32'(busy), 32'd0);
    chk("glitch_rdy_count", 32'(rdy_times.size()), 32'd1);
    chk("glitch_fe_count", 32'(fe_count), 32'd0);

    // Bad stop bit followed by a held-low break.
    send(8'hA5, 1'b0, 1600);
    idle(200);
    rx_in = 1'b1;
    idle(20);
    chk("break_fe_count", 32'(fe_count), 32'd1);
    chk("break_fe_pending", 32'(fe_pending), 32'd0);
    chk("break_rdy_count", 32'(rdy_times.size()), 32'd1);
    chk("break_data_hold", 32'(data_out), 32'h65);
    chk("break_busy", 32'(busy), 32'd0);

    send(8'h3C, 1'b1, 1600);
    idle(4);
    chk("after_break_0x3C", 32'(data_out), 32'h3C);
    chk("after_break_rdy_count", 32'(rdy_times.size()), 32'd2);

    // Back-to-back frames with no idle gap.
    base = rdy_times.size();
    send(8'h61, 1'b1, 1600);
    send(8'h12, 1'b1, 1600);
    send(8'h34, 1'b1, 1600);
    idle(4);
    chk("b2b_rdy_count", 32'(rdy_times.size()), 32'(base + 3));
    if (rdy_times.size() == base + 3) begin
      chk("b2b_gap_1", 32'(rdy_times[base + 1] - rdy_times[base]), 32'd160);
      chk("b2b_gap_2", 32'(rdy_times[base + 2] - rdy_times[base + 1]), 32'd160);
    end
    chk("b2b_last", 32'(data_out), 32'h34);

    // Reset in the middle of a 0xFF frame, after three data bits.
    rx_in = 1'b0;
    idle(CPB);
    rx_in = 1'b1;
    idle(3 * CPB);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk_in);
    chk("midreset_data_out", 32'(data_out), 32'h00);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rdy", 32'(data_rdy), 32'd0);
    chk("midreset_ferr", 32'(frame_err), 32'd0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    idle(40);
    chk("post_reset_rdy_count", 32'(rdy_times.size()), 32'(base + 3));
    chk("post_reset_data_out", 32'(data_out), 32'h00);
    send(8'h81, 1'b1, 1600);
    idle(4);
    chk("post_reset_0x81", 32'(data_out), 32'h81);

    // Sender rate 3% slow, then 3% fast.
    send(8'h55, 1'b1, 1648);
    idle(5);
    chk("slow_0x55", 32'(data_out), 32'h55);
    send(8'hAA, 1'b1, 1552);
    idle(5);
    chk("fast_0xAA", 32'(data_out), 32'hAA);
    chk("tol_fe_count", 32'(fe_count), 32'd1);
    chk("total_rdy_count", 32'(rdy_times.size()), 32'(base + 6));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("fe_pending_empty", 32'(fe_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
